// File: rtl/keypad_hit_queue_if.sv
// rtl/keypad_hit_queue_if.sv - valid/ready hit handshake between the keypad queue and the game logic
interface keypad_hit_queue_if;
  logic       hitValid;
  logic       hitReady;
  logic [3:0] hitPos;
  logic       hitIsCtrl;

  modport master (output hitValid, output hitPos, output hitIsCtrl, input hitReady);
  modport slave  (input hitValid, input hitPos, input hitIsCtrl, output hitReady);
endinterface

// File: rtl/keypad_hit_queue.sv
// rtl/keypad_hit_queue.sv - one queued event per keypad press, handed to game logic over valid/ready
// Optional feature macro KEYPAD_CTRL_PASS_EN: also queue codes 0/a..f, flagged by hitIsCtrl.
module keypad_hit_queue #(
  parameter int DEPTH          = 4,
  parameter int CODE_WAIT      = 4,
  parameter int RELEASE_CYCLES = 12
) (
  input  logic                clk_div,
  input  logic                reset,
  input  logic [3:0]          keypadCol,
  input  logic [3:0]          keypadBuf,
  keypad_hit_queue_if.master  hit,
  output logic                hitOvf,
  output logic                pressed
);
  localparam int AW     = $clog2(DEPTH);
  localparam int PTR_W  = AW + 1;
  localparam int WAIT_W = $clog2(CODE_WAIT + 1);
  localparam int REL_W  = $clog2(RELEASE_CYCLES + 1);
`ifdef KEYPAD_CTRL_PASS_EN
  localparam int ENTRY_W = 5;
`else
  localparam int ENTRY_W = 4;
`endif

  typedef enum logic [1:0] {ARMED, WAIT_CODE, HELD} state_t;

  state_t             state;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [REL_W-1:0]   rel_cnt;
  logic [3:0]         code_q;
  logic               push_req;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               col_idle;
  logic               code_is_pos;
  logic               push_valid;
  logic               fifo_empty;
  logic               fifo_full;
  logic               pop;
  logic               push_ok;
  logic [ENTRY_W-1:0] head;
  logic [ENTRY_W-1:0] push_entry;

  assign col_idle    = (keypadCol == 4'hF);
  assign code_is_pos = (code_q != 4'h0) && (code_q <= 4'h9);

`ifdef KEYPAD_CTRL_PASS_EN
  assign push_valid = push_req;
  assign push_entry = {~code_is_pos, code_q};
`else
  assign push_valid = push_req && code_is_pos;
  assign push_entry = code_q;
`endif

  // Press detector: a new event only after a full release window of idle columns.
  always_ff @(posedge clk_div or negedge reset) begin
    if (!reset) begin
      state    <= ARMED;
      wait_cnt <= '0;
      rel_cnt  <= '0;
      code_q   <= 4'h0;
      push_req <= 1'b0;
      pressed  <= 1'b0;
    end else begin
      push_req <= 1'b0;
      case (state)
        ARMED: begin
          if (!col_idle) begin
            state    <= WAIT_CODE;
            wait_cnt <= '0;
            pressed  <= 1'b1;
          end
        end
        WAIT_CODE: begin
          // Columns may already be high again here; the scanner code is still valid.
          if (wait_cnt == WAIT_W'(CODE_WAIT - 1)) begin
            code_q   <= keypadBuf;
            push_req <= 1'b1;
            state    <= HELD;
            wait_cnt <= '0;
            rel_cnt  <= '0;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        HELD: begin
          if (col_idle) begin
            if (rel_cnt == REL_W'(RELEASE_CYCLES - 1)) begin
              state   <= ARMED;
              rel_cnt <= '0;
              pressed <= 1'b0;
            end else begin
              rel_cnt <= rel_cnt + REL_W'(1);
            end
          end else begin
            rel_cnt <= '0;
          end
        end
        default: begin
          state   <= ARMED;
          pressed <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = !fifo_empty && hit.hitReady;
  assign push_ok    = push_valid && (!fifo_full || pop);

  always_ff @(posedge clk_div or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      hitOvf <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= push_entry;
        wr_ptr              <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push_valid && !push_ok) begin
        hitOvf <= 1'b1;
      end
    end
  end

  assign head         = mem[rd_ptr[AW-1:0]];
  assign hit.hitValid = !fifo_empty;
  assign hit.hitPos   = fifo_empty ? 4'h0 : head[3:0];
`ifdef KEYPAD_CTRL_PASS_EN
  assign hit.hitIsCtrl = !fifo_empty && head[4];
`else
  assign hit.hitIsCtrl = 1'b0;
`endif
endmodule
